// File: rtl/qam_symbol_buffer.sv
// Qualifies modulator alignment markers with a period-lock FSM and buffers one
// symbol per qualified marker in a first-word fall-through FIFO.
module qam_symbol_buffer #(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned LOCK_COUNT = 4,
    parameter int unsigned PERIOD_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     m_align,
    input  logic [2:0]               A_reg,
    output logic [2:0]               sym_data,
    output logic                     sym_valid,
    input  logic                     sym_ready,
    output logic                     locked,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   fill,
    output logic [15:0]              sym_count
);

    localparam int unsigned AddrW  = $clog2(DEPTH);
    localparam int unsigned MatchW = $clog2(LOCK_COUNT + 1);

    typedef enum logic [1:0] {StSearch, StTrack, StLocked} state_e;

    state_e              state_q, state_d;
    logic                m_align_q;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [PERIOD_W-1:0] ref_q, ref_d;
    logic [MatchW-1:0]   match_q, match_d;
    logic [AddrW:0]      wr_ptr_q, rd_ptr_q;
    logic [2:0]          mem [DEPTH];
    logic                overflow_q;
    logic [15:0]         sym_count_q;

    logic                strobe, near, late, qualified;
    logic                empty, full, push, pop, drop;
    logic [PERIOD_W:0]   cnt_ext, ref_ext;

    assign strobe = m_align & ~m_align_q;

    // Period comparisons carry one extra bit so 2*ref and ref+1 cannot wrap.
    assign cnt_ext = {1'b0, cnt_q};
    assign ref_ext = {1'b0, ref_q};
    assign near    = (cnt_ext <= ref_ext + (PERIOD_W + 1)'(1)) &&
                     (ref_ext <= cnt_ext + (PERIOD_W + 1)'(1));
    assign late    = cnt_ext > {ref_q, 1'b0};

    always_comb begin
        if (strobe) begin
            cnt_d = PERIOD_W'(1);
        end else if (&cnt_q) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + PERIOD_W'(1);
        end
    end

    always_comb begin
        state_d   = state_q;
        ref_d     = ref_q;
        match_d   = match_q;
        qualified = 1'b0;
        unique case (state_q)
            StSearch: begin
                if (strobe) begin
                    state_d = StTrack;
                    match_d = '0;
                end
            end
            StTrack: begin
                if (strobe) begin
                    // match_q == 0 means no reference period recorded yet.
                    if (match_q == '0 || !near) begin
                        ref_d   = cnt_q;
                        match_d = MatchW'(1);
                    end else begin
                        match_d = match_q + MatchW'(1);
                    end
                    if (match_d == MatchW'(LOCK_COUNT)) begin
                        state_d = StLocked;
                    end
                end else if (match_q != '0 && late) begin
                    state_d = StSearch;
                end
            end
            StLocked: begin
                if (strobe) begin
                    if (near) begin
                        qualified = 1'b1;
                    end else begin
                        state_d = StSearch;
                    end
                end else if (late) begin
                    state_d = StSearch;
                end
            end
            default: state_d = StSearch;
        endcase
    end

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                   (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
    assign pop   = ~empty & sym_ready;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign push  = qualified & (~full | pop);
    assign drop  = qualified & full & ~pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StSearch;
            m_align_q   <= 1'b0;
            cnt_q       <= '0;
            ref_q       <= '0;
            match_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            sym_count_q <= '0;
        end else begin
            state_q   <= state_d;
            m_align_q <= m_align;
            cnt_q     <= cnt_d;
            ref_q     <= ref_d;
            match_q   <= match_d;
            if (push) begin
                wr_ptr_q    <= wr_ptr_q + (AddrW + 1)'(1);
                sym_count_q <= sym_count_q + 16'd1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + (AddrW + 1)'(1);
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q[AddrW-1:0]] <= A_reg;
        end
    end

    assign sym_valid = ~empty;
    assign sym_data  = empty ? 3'd0 : mem[rd_ptr_q[AddrW-1:0]];
    assign locked    = (state_q == StLocked);
    assign overflow  = overflow_q;
    assign fill      = wr_ptr_q - rd_ptr_q;
    assign sym_count = sym_count_q;

endmodule

// File: tb/tb_qam_symbol_buffer.sv
// Bench for qam_symbol_buffer: directed scenarios with literal expectations plus
// randomized marker streams checked every cycle against a behavioural model.
module tb_qam_symbol_buffer;

    localparam int DEPTH      = 16;
    localparam int LOCK_COUNT = 4;
    localparam int PERIOD_W   = 16;

    logic        clk = 1'b0;
    logic        rst, m_align, sym_ready;
    logic [2:0]  A_reg, sym_data;
    logic        sym_valid, locked, overflow;
    logic [4:0]  fill;
    logic [15:0] sym_count;

    always #5 clk = ~clk;

    qam_symbol_buffer #(
        .DEPTH      (DEPTH),
        .LOCK_COUNT (LOCK_COUNT),
        .PERIOD_W   (PERIOD_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .m_align   (m_align),
        .A_reg     (A_reg),
        .sym_data  (sym_data),
        .sym_valid (sym_valid),
        .sym_ready (sym_ready),
        .locked    (locked),
        .overflow  (overflow),
        .fill      (fill),
        .sym_count (sym_count)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: mode 0 = search, 1 = track, 2 = locked.
    int         m_mode, m_since, m_ref, m_match, m_count;
    bit         m_prev, m_ovf;
    bit         started = 1'b0;
    logic [2:0] m_q [$];

    task automatic model_step();
        bit strobe, pop, qual, near, late, full;
        int period;
        if (rst) begin
            m_mode = 0; m_since = 0; m_ref = 0; m_match = 0; m_count = 0;
            m_prev = 1'b0; m_ovf = 1'b0;
            m_q.delete();
            return;
        end
        strobe = m_align && !m_prev;
        m_prev = m_align;
        period = m_since;
        near   = (period - m_ref <= 1) && (m_ref - period <= 1);
        late   = period > 2 * m_ref;
        qual   = 1'b0;
        case (m_mode)
            0: if (strobe) begin m_mode = 1; m_match = 0; end
            1: begin
                if (strobe) begin
                    if (m_match > 0 && near) m_match++;
                    else begin m_ref = period; m_match = 1; end
                    if (m_match >= LOCK_COUNT) m_mode = 2;
                end else if (m_match > 0 && late) m_mode = 0;
            end
            default: begin
                if (strobe) begin
                    if (near) qual = 1'b1; else m_mode = 0;
                end else if (late) m_mode = 0;
            end
        endcase
        full = (m_q.size() == DEPTH);
        pop  = (m_q.size() > 0) && sym_ready;
        if (pop) void'(m_q.pop_front());
        if (qual) begin
            if (!full || pop) begin
                m_q.push_back(A_reg);
                m_count = (m_count + 1) % 65536;
            end else m_ovf = 1'b1;
        end
        if (strobe) m_since = 1;
        else if (m_since < (1 << PERIOD_W) - 1) m_since++;
    endtask

    always @(posedge clk) begin
        model_step();
        started = 1'b1;
    end

    always @(negedge clk) begin
        if (started) begin
            logic       e_valid, e_locked;
            logic [2:0] e_data;
            logic [4:0] e_fill;
            e_valid  = (m_q.size() > 0);
            e_data   = e_valid ? m_q[0] : 3'd0;
            e_locked = (m_mode == 2);
            e_fill   = 5'(m_q.size());
            tests++;
            if (sym_valid !== e_valid || (e_valid && sym_data !== e_data) ||
                locked !== e_locked || overflow !== m_ovf || fill !== e_fill ||
                sym_count !== 16'(m_count)) begin
                fails++;
                $display("FAIL model_cycle t=%0t got v=%b d=%0d l=%b o=%b f=%0d c=%0d required v=%b d=%0d l=%b o=%b f=%0d c=%0d",
                         $time, sym_valid, sym_data, locked, overflow, fill, sym_count,
                         e_valid, e_data, e_locked, m_ovf, e_fill, 16'(m_count));
            end
        end
    end

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s t=%0t: got %0d, required %0d", name, $time, got, exp);
        end
    endtask

    task automatic cyc(input bit al, input logic [2:0] a);
        m_align = al;
        A_reg   = a;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 3'($urandom));
    endtask

    // Next strobe lands exactly p clocks after the previous one.
    task automatic strobe_after(input int p, input logic [2:0] s);
        idle(p - 1);
        cyc(1'b1, s);
    endtask

    logic [2:0] syms [18];

    initial begin
        rst = 1'b1; m_align = 1'b0; A_reg = 3'd0; sym_ready = 1'b0;

        for (int i = 0; i < 3; i++) begin
            m_align = 1'($urandom); A_reg = 3'($urandom); sym_ready = 1'($urandom);
            @(negedge clk);
            check("reset_valid", 16'(sym_valid), 16'd0);
            check("reset_data", 16'(sym_data), 16'd0);
            check("reset_locked", 16'(locked), 16'd0);
            check("reset_overflow", 16'(overflow), 16'd0);
            check("reset_fill", 16'(fill), 16'd0);
            check("reset_count", sym_count, 16'd0);
        end
        rst = 1'b0; sym_ready = 1'b1; m_align = 1'b0;

        for (int k = 0; k < 10; k++) begin
            strobe_after(8, 3'(k % 8));
            check("lock_rise", 16'(locked), 16'(k >= 4));
            if (k >= 5) begin
                check("capture_valid", 16'(sym_valid), 16'd1);
                check("capture_data", 16'(sym_data), 16'(k % 8));
                check("capture_count", sym_count, 16'(k - 4));
            end
        end

        strobe_after(7, 3'd2);
        check("jitter7_locked", 16'(locked), 16'd1);
        check("jitter7_data", 16'(sym_data), 16'd2);
        strobe_after(9, 3'd3);
        check("jitter9_locked", 16'(locked), 16'd1);
        check("jitter9_data", 16'(sym_data), 16'd3);
        strobe_after(10, 3'd4);
        check("jitter10_locked", 16'(locked), 16'd0);
        check("jitter10_absent", 16'(sym_valid), 16'd0);
        for (int k = 1; k <= 5; k++) begin
            strobe_after(8, 3'(k));
            check("relock", 16'(locked), 16'(k == 5));
        end

        sym_ready = 1'b0;
        for (int j = 0; j < 17; j++) begin
            syms[j] = 3'($urandom);
            strobe_after(8, syms[j]);
            check("ovf_fill", 16'(fill), 16'(j < 16 ? j + 1 : 16));
            check("ovf_flag", 16'(overflow), 16'(j == 16));
        end
        idle(7);
        check("full_head", 16'(sym_data), 16'(syms[0]));
        sym_ready = 1'b1;
        syms[17] = 3'($urandom);
        cyc(1'b1, syms[17]);
        check("full_push_fill", 16'(fill), 16'd16);
        check("full_push_count", sym_count, 16'd24);
        for (int j = 1; j <= 16; j++) begin
            check("drain_valid", 16'(sym_valid), 16'd1);
            check("drain_data", 16'(sym_data), 16'(j < 16 ? syms[j] : syms[17]));
            idle(1);
        end
        check("drain_empty", 16'(fill), 16'd0);

        idle(20);
        sym_ready = 1'b0;
        for (int k = 0; k < 5; k++) strobe_after(8, 3'($urandom));
        check("to_lock", 16'(locked), 16'd1);
        for (int j = 0; j < 3; j++) begin
            syms[j] = 3'($urandom);
            strobe_after(8, syms[j]);
        end
        idle(16);
        check("timeout_hold", 16'(locked), 16'd1);
        idle(1);
        check("timeout_drop", 16'(locked), 16'd0);
        check("timeout_fill", 16'(fill), 16'd3);
        sym_ready = 1'b1;
        for (int j = 0; j < 3; j++) begin
            check("timeout_data", 16'(sym_data), 16'(syms[j]));
            idle(1);
        end

        idle(20);
        sym_ready = 1'b0;
        for (int k = 0; k < 10; k++) strobe_after(8, 3'($urandom));
        check("pre_reset_fill", 16'(fill), 16'd5);
        check("pre_reset_ovf", 16'(overflow), 16'd1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check("midrst_locked", 16'(locked), 16'd0);
        check("midrst_fill", 16'(fill), 16'd0);
        check("midrst_valid", 16'(sym_valid), 16'd0);
        check("midrst_count", sym_count, 16'd0);
        check("midrst_ovf", 16'(overflow), 16'd0);
        for (int k = 1; k <= 5; k++) begin
            strobe_after(8, 3'($urandom));
            check("midrst_relock", 16'(locked), 16'(k == 5));
        end

        for (int b = 0; b < 12; b++) begin
            int base;
            int rdy_pct;
            base    = $urandom_range(12, 4);
            rdy_pct = $urandom_range(100, 10);
            for (int s = 0; s < 30; s++) begin
                int p;
                int w;
                p = base + $urandom_range(2, 0) - 1;
                if ($urandom_range(15, 0) == 0) p = base * 2 + $urandom_range(4, 0);
                w = $urandom_range(3, 1);
                if (w >= p) w = 1;
                for (int c = 0; c < p; c++) begin
                    m_align   = (c < w);
                    A_reg     = 3'($urandom);
                    sym_ready = ($urandom_range(99, 0) < rdy_pct);
                    rst       = ($urandom_range(499, 0) == 0);
                    @(negedge clk);
                end
            end
        end
        rst = 1'b0;
        idle(4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/qam_symbol_buffer.md
# qam_symbol_buffer

Receives the 3-bit amplitude symbol stream (`A_reg`) and its alignment marker (`m_align`) from `DigitalQAMModulation`, qualifies the marker with a period-lock state machine, and captures one symbol per qualified marker into a FIFO. The FIFO presents the symbols to the next stage over a valid/ready handshake. Status outputs report lock, sticky overflow and the captured-symbol count. The block is purely synchronous to `clk`, the same clock that drives the modulator.

## Interface
- `DEPTH`, 16, FIFO depth in symbols; must be a power of 2 and at least 2.
- `LOCK_COUNT`, 4, number of consecutive matching periods required to enter LOCKED; at least 1.
- `PERIOD_W`, 16, width of the marker-period counter.

- `clk` input 1: system clock, single clock domain.
- `rst` input 1: synchronous, active-high reset.
- `m_align` input 1: symbol alignment marker from the modulator, a level synchronous to `clk`.
- `A_reg` input 3: current symbol amplitude code.
- `sym_data` output 3: FIFO head symbol. The FIFO is first-word fall-through.
- `sym_valid` output 1: FIFO is non-empty.
- `sym_ready` input 1: downstream accepts `sym_data` this cycle.
- `locked` output 1: the state machine is in LOCKED.
- `overflow` output 1: sticky flag, set when a qualified symbol is dropped because the FIFO is full.
- `fill` output $clog2(DEPTH)+1: current FIFO occupancy.
- `sym_count` output 16: number of symbols written to the FIFO; wraps modulo 2^16.

## Operation
- **Strobe.**
  - `strobe = m_align & ~m_align_q`, where `m_align_q` is `m_align` registered once.
  - `A_reg` is sampled in the strobe cycle.
- **Period counter `cnt`** (PERIOD_W bits):
  - Loads 1 on a strobe, otherwise increments.
  - Saturates at all-ones.
  - At a strobe, `cnt` equals the number of clocks since the previous strobe.
- **Match rule.** `|cnt - ref| <= 1`, where `ref` is the recorded reference period.
- **Timeout rule.** `cnt > 2*ref`, evaluated at PERIOD_W+1 bits.
- **State SEARCH.** Initial state after reset.
  - A strobe moves to TRACK and clears `match`.
- **State TRACK.**
  - First strobe in TRACK: `ref <= cnt`, `match <= 1`.
  - Later strobe that matches: `match++`.
  - Later strobe that does not match: `ref <= cnt`, `match <= 1`.
  - When `match` reaches LOCK_COUNT, move to LOCKED.
  - The symbol on the lock-causing strobe is not written.
  - Timeout with a valid `ref` returns to SEARCH.
- **State LOCKED.**
  - Strobe that matches: the symbol is qualified.
  - Strobe that does not match: go to SEARCH; the symbol is not written.
  - Timeout: go to SEARCH.
  - `ref` is not updated while in LOCKED.
- **FIFO write.**
  - A qualified symbol is pushed if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
  - Otherwise the symbol is dropped and `overflow` is set.
  - Each accepted push increments `sym_count`.
- **FIFO read.** Pop when `sym_valid & sym_ready`. A pop while empty is ignored.
- **Simultaneous push and pop.** `fill` is unchanged. Order is preserved.
- **Pointer wrap.** Pointers are $clog2(DEPTH)+1 bits; full and empty are distinguished by the MSB.
- **Lock loss.** FIFO contents are kept when lock is lost; downstream continues to drain them.
- **Reset**, including mid-operation:
  - State returns to SEARCH; `cnt`, `ref` and `match` clear.
  - FIFO is flushed.
  - All outputs go to their reset values.

## Timing
- **Reset values.** `sym_valid`=0, `sym_data`=0, `locked`=0, `overflow`=0, `fill`=0, `sym_count`=0.
- **Strobe detection.** A strobe is detected in the first clock in which `m_align` is seen high after a low. The `A_reg` value at that clock edge is the captured symbol.
- **Write latency.** A qualified symbol is written at the strobe edge:
  - `sym_valid` and `fill` update one cycle after the strobe.
  - `sym_data` shows that symbol in the same cycle if the FIFO was empty.
- **Lock latency.** `locked` rises one cycle after the strobe at which `match` reaches LOCK_COUNT. With the default LOCK_COUNT of 4 this is the 5th strobe after SEARCH.
- **Lock release.** `locked` falls one cycle after the mismatching strobe, or one cycle after the first cycle in which `cnt > 2*ref`.
- **Handshake.**
  - `sym_data` is stable while `sym_valid=1` and `sym_ready=0`.
  - A pop takes effect at the clock edge.
- **Overflow.** `overflow` rises one cycle after the first dropped symbol and stays high until `rst`.

## Test plan
1. **Reset values.** Assert `rst` for 3 cycles with random inputs → all outputs hold their reset values; `fill`=0.
2. **Lock and capture.**
   - Stimulus: `m_align` 1-cycle pulse every 8 clocks; `A_reg` = strobe index mod 8, starting at 0; `sym_ready`=1.
   - Response: `locked` rises after strobe index 4; the first symbol read is 5, then 6, 7, 0 …; `sym_count` increments once per strobe from index 5.
3. **Jitter tolerance.**
   - With lock held, a 7- or 9-cycle period is tolerated: `locked` stays 1 and the symbol is written.
   - A 10-cycle period drops `locked`, that symbol is absent from the output, and relock takes 5 further strobes.
4. **Overflow.**
   - Stimulus: locked stream with `sym_ready`=0 for 17 qualified strobes.
   - Response: `fill`=16 (DEPTH); `overflow`=1 after the 17th strobe; draining returns exactly the first 16 symbols in order.
   - Then assert `sym_ready`=1 on a full FIFO coincident with a strobe → push accepted and `fill` stays 16.
5. **Timeout.** Stop `m_align` after lock with `ref`=8 → `locked` falls one cycle after `cnt` reaches 17; buffered symbols remain readable.
6. **Mid-operation reset.** Pulse `rst` for 1 cycle while locked with `fill`=5 → SEARCH state, `fill`=0, `sym_valid`=0, `sym_count`=0, `overflow`=0; relock then requires 5 strobes.
